// File: rtl/butterfly_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_pkg
//   Shared constants, enums and modular helper functions for the NTT butterfly.
//   Holds the Kyber and Dilithium moduli, the Barrett reduction constants and
//   the datapath widths.
//
// Configuration macro: BUTTERFLY_KYBER_EN. When it is defined, the package also
//   carries the Kyber Barrett constants.
// -----------------------------------------------------------------------------
package butterfly_pkg;

  localparam int unsigned DATA_W = 23;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [DATA_W-1:0] Q_KYBER     = 23'd3329;
  localparam logic [DATA_W-1:0] Q_DILITHIUM = 23'd8380417;

  // The Barrett shift k is chosen so that 2^k exceeds the largest product
  // (q-1)^2. This keeps the quotient estimate within one of the true value, so
  // a single conditional subtraction is enough to finish the reduction.
  localparam int unsigned K_DILITHIUM = 46;
  localparam logic [23:0] M_DILITHIUM =
    24'((64'd1 << K_DILITHIUM) / 64'(Q_DILITHIUM));

`ifdef BUTTERFLY_KYBER_EN
  localparam int unsigned K_KYBER = 24;
  localparam logic [12:0] M_KYBER =
    13'((64'd1 << K_KYBER) / 64'(Q_KYBER));
`endif

  typedef enum logic {
    RED_DILITHIUM = 1'b0,
    RED_KYBER     = 1'b1
  } red_sel_e;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_sel_e;

  // Returns x mod q for 0 <= x < 2q.
  function automatic logic [DATA_W-1:0] cond_sub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] q);
    return (x >= q) ? x - q : x;
  endfunction

  // Returns (x + y) mod q for x, y in [0,q).
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? DATA_W'(s - {1'b0, q}) : DATA_W'(s);
  endfunction

  // Returns (x - y) mod q for x, y in [0,q). A borrow shows up in the top bit.
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[DATA_W] ? DATA_W'(d + {1'b0, q}) : DATA_W'(d);
  endfunction

endpackage

// File: rtl/butterfly_mod_reduce.sv
// -----------------------------------------------------------------------------
// mod_reduce
//   Combinational Barrett reduction of a product below q^2 down to [0,q).
//   prod    : product to reduce (up to 46 bits)
//   red     : modulus select (Kyber / Dilithium)
//   residue : prod mod q
// Configuration macro: BUTTERFLY_KYBER_EN. Without it, only the Dilithium
//   path exists and red is not used.
// -----------------------------------------------------------------------------
module mod_reduce
  import butterfly_pkg::*;
(
  input  logic [PROD_W-1:0] prod,
  input  red_sel_e          red,
  output logic [DATA_W-1:0] residue
);

  logic [23:0]       qhat_dil;
  logic [23:0]       r_dil;
  logic [DATA_W:0]   r_sel;
  logic [DATA_W-1:0] q_sel;

  assign qhat_dil = 24'((70'(prod) * 70'(M_DILITHIUM)) >> K_DILITHIUM);
  assign r_dil    = 24'(prod - (46'(qhat_dil) * 46'(Q_DILITHIUM)));

`ifdef BUTTERFLY_KYBER_EN
  // Kyber products fit in 24 bits because both operands are below 3329.
  logic [12:0] qhat_ky;
  logic [13:0] r_ky;

  assign qhat_ky = 13'((37'(prod[23:0]) * 37'(M_KYBER)) >> K_KYBER);
  assign r_ky    = 14'(prod[23:0] - (24'(qhat_ky) * 24'(Q_KYBER)));
  assign r_sel   = (red == RED_KYBER) ? {10'b0, r_ky} : r_dil;
  assign q_sel   = (red == RED_KYBER) ? Q_KYBER : Q_DILITHIUM;
`else
  logic unused_red;
  assign unused_red = red;
  assign r_sel      = r_dil;
  assign q_sel      = Q_DILITHIUM;
`endif

  assign residue = (r_sel >= {1'b0, q_sel}) ? DATA_W'(r_sel - {1'b0, q_sel})
                                            : DATA_W'(r_sel);

endmodule

// File: rtl/butterfly.sv
// -----------------------------------------------------------------------------
// butterfly
//   Pipelined modular NTT butterfly (Cooley-Tukey / Gentleman-Sande) over the
//   Kyber or Dilithium modulus. Latency is 3 and one operation is accepted
//   per cycle.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   valid_i          : operands valid
//   a_i, b_i         : operands (bit 23 ignored)
//   twiddle_i        : twiddle factor w
//   sel_red_i        : 1 = Kyber, 0 = Dilithium
//   sel_butterfly_i  : 0 = CT, 1 = GS
//   valid_o          : result valid
//   a_prime_o/b_prime_o : results in [0,q), held between valid results
// Configuration macro: BUTTERFLY_KYBER_EN enables Kyber mode. Without it,
//   sel_red_i is ignored and every operation uses the Dilithium modulus.
// -----------------------------------------------------------------------------
module butterfly
  import butterfly_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic [22:0] twiddle_i,
  input  logic        sel_red_i,
  input  logic        sel_butterfly_i,
  output logic        valid_o,
  output logic [22:0] a_prime_o,
  output logic [22:0] b_prime_o
);

  red_sel_e          red_in;
  bf_sel_e           bf_in;
  logic [DATA_W-1:0] q_in, q_s1, q_s2;
  logic [DATA_W-1:0] a_fld, b_fld, w_fld;
  logic              unused_bits;

  // Stage registers. The mode travels with the data so that a mode change
  // between cycles cannot affect operations already in the pipeline.
  logic              s1_valid, s2_valid;
  red_sel_e          s1_red, s2_red;
  bf_sel_e           s1_bf, s2_bf;
  logic [DATA_W-1:0] s1_a, s1_b, s1_w;
  logic [DATA_W-1:0] s2_a;
  logic [PROD_W-1:0] s2_prod;

  logic [DATA_W-1:0] gs_sum, gs_diff, mul_in, pass_a;
  logic [DATA_W-1:0] t_red, a_res, b_res;

`ifdef BUTTERFLY_KYBER_EN
  assign red_in      = red_sel_e'(sel_red_i);
  assign q_in        = (red_in == RED_KYBER) ? Q_KYBER : Q_DILITHIUM;
  assign q_s1        = (s1_red == RED_KYBER) ? Q_KYBER : Q_DILITHIUM;
  assign q_s2        = (s2_red == RED_KYBER) ? Q_KYBER : Q_DILITHIUM;
  assign unused_bits = ^{a_i[23], b_i[23]};
`else
  assign red_in      = RED_DILITHIUM;
  assign q_in        = Q_DILITHIUM;
  assign q_s1        = Q_DILITHIUM;
  assign q_s2        = Q_DILITHIUM;
  assign unused_bits = ^{a_i[23], b_i[23], sel_red_i};
`endif

  assign bf_in = bf_sel_e'(sel_butterfly_i);

  // Operand field capture: Kyber uses only the low 12 bits of each operand.
  always_comb begin
    // NOTE: defaults come first so that every path assigns every output and no latch is inferred.
    a_fld = a_i[22:0];
    b_fld = b_i[22:0];
    w_fld = twiddle_i;
`ifdef BUTTERFLY_KYBER_EN
    if (red_in == RED_KYBER) begin
      a_fld = {11'b0, a_i[11:0]};
      b_fld = {11'b0, b_i[11:0]};
      w_fld = {11'b0, twiddle_i[11:0]};
    end
`endif
  end

  // Stage 1: register operands, already reduced to [0,q). Every field is
  // below 2q, so one conditional subtraction gives the canonical residue.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so that all registers sample their pre-edge values.
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_red   <= RED_DILITHIUM;
      s1_bf    <= BF_CT;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_w     <= '0;
    end else begin
      s1_valid <= valid_i;
      s1_red   <= red_in;
      s1_bf    <= bf_in;
      s1_a     <= cond_sub(a_fld, q_in);
      s1_b     <= cond_sub(b_fld, q_in);
      s1_w     <= cond_sub(w_fld, q_in);
    end
  end

  // Stage 2: CT multiplies b*w. GS forms a+b and (a-b)*w, so its modular
  // add and subtract happen ahead of the multiplier.
  assign gs_sum  = mod_add(s1_a, s1_b, q_s1);
  assign gs_diff = mod_sub(s1_a, s1_b, q_s1);
  assign mul_in  = (s1_bf == BF_GS) ? gs_diff : s1_b;
  assign pass_a  = (s1_bf == BF_GS) ? gs_sum : s1_a;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_red   <= RED_DILITHIUM;
      s2_bf    <= BF_CT;
      s2_a     <= '0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_red   <= s1_red;
      s2_bf    <= s1_bf;
      s2_a     <= pass_a;
      s2_prod  <= PROD_W'(mul_in) * PROD_W'(s1_w);
    end
  end

  // Stage 3: reduce the product, then finish the CT add/sub.
  mod_reduce u_mod_reduce (
    .prod    (s2_prod),
    .red     (s2_red),
    .residue (t_red)
  );

  assign a_res = (s2_bf == BF_CT) ? mod_add(s2_a, t_red, q_s2) : s2_a;
  assign b_res = (s2_bf == BF_CT) ? mod_sub(s2_a, t_red, q_s2) : t_red;

  // The result registers load only with a valid result and hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      a_prime_o <= '0;
      b_prime_o <= '0;
    end else begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        a_prime_o <= a_res;
        b_prime_o <= b_res;
      end
    end
  end

endmodule

// File: tb/tb_butterfly.sv
// -----------------------------------------------------------------------------
// tb_butterfly
//   Self-checking bench for butterfly. Expected results come from plain modular
//   arithmetic. A scoreboard records, for each issued operation, the cycle in
//   which its result is due and the result itself. Every cycle the bench checks
//   valid_o and both result ports: they must carry the due result, or else
//   still hold the previous result.
// -----------------------------------------------------------------------------
module tb_butterfly;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [23:0] a_i, b_i;
  logic [22:0] twiddle_i;
  logic        sel_red_i, sel_butterfly_i;
  logic        valid_o;
  logic [22:0] a_prime_o, b_prime_o;

  always #5 clk_i = ~clk_i;

  butterfly dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .twiddle_i       (twiddle_i),
    .sel_red_i       (sel_red_i),
    .sel_butterfly_i (sel_butterfly_i),
    .valid_o         (valid_o),
    .a_prime_o       (a_prime_o),
    .b_prime_o       (b_prime_o)
  );

  typedef struct {
    int          due;
    logic [22:0] a;
    logic [22:0] b;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [22:0] last_a = '0;
  logic [22:0] last_b = '0;

  task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Reference model: field capture, canonical residue, then the butterfly.
  function automatic void model(input logic red, input logic bf,
                                input logic [23:0] a, input logic [23:0] b,
                                input logic [22:0] w,
                                output logic [22:0] ea, output logic [22:0] eb);
    longint unsigned q, fm, av, bv, wv, t, d;
    logic ky;
`ifdef BUTTERFLY_KYBER_EN
    ky = red;
`else
    ky = 1'b0;
`endif
    q  = ky ? 64'd3329 : 64'd8380417;
    fm = ky ? 64'hFFF : 64'h7FFFFF;
    av = (64'(a) & fm) % q;
    bv = (64'(b) & fm) % q;
    wv = (64'(w) & fm) % q;
    if (!bf) begin
      t  = (bv * wv) % q;
      ea = 23'((av + t) % q);
      eb = 23'((av + q - t) % q);
    end else begin
      d  = (av + q - bv) % q;
      ea = 23'((av + bv) % q);
      eb = 23'((d * wv) % q);
    end
  endfunction

  // One clock: advance, then compare all outputs against the scoreboard.
  task automatic step();
    @(posedge clk_i);
    cyc++;
    #1;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      check("valid_o_result", 23'(valid_o), 23'd1);
      check("a_prime", a_prime_o, sb[0].a);
      check("b_prime", b_prime_o, sb[0].b);
      last_a = sb[0].a;
      last_b = sb[0].b;
      void'(sb.pop_front());
    end else begin
      check("valid_o_idle", 23'(valid_o), 23'd0);
      check("a_prime_hold", a_prime_o, last_a);
      check("b_prime_hold", b_prime_o, last_b);
    end
  endtask

  task automatic issue(input logic red, input logic bf, input logic [23:0] a,
                       input logic [23:0] b, input logic [22:0] w,
                       input logic [22:0] ea, input logic [22:0] eb);
    exp_t e;
    valid_i         = 1'b1;
    sel_red_i       = red;
    sel_butterfly_i = bf;
    a_i             = a;
    b_i             = b;
    twiddle_i       = w;
    e.due = cyc + 3;
    e.a   = ea;
    e.b   = eb;
    sb.push_back(e);
    step();
  endtask

  task automatic issue_model(input logic red, input logic bf, input logic [23:0] a,
                             input logic [23:0] b, input logic [22:0] w);
    logic [22:0] ea, eb;
    model(red, bf, a, b, w, ea, eb);
    issue(red, bf, a, b, w, ea, eb);
  endtask

  // Kyber reference vectors. Without Kyber support, the operation runs as Dilithium.
  task automatic issue_kyber(input logic bf, input logic [23:0] a, input logic [23:0] b,
                             input logic [22:0] w, input logic [22:0] ea,
                             input logic [22:0] eb);
`ifdef BUTTERFLY_KYBER_EN
    issue(1'b1, bf, a, b, w, ea, eb);
`else
    logic [22:0] unused_a, unused_b;
    unused_a = ea;
    unused_b = eb;
    issue_model(1'b1, bf, a, b, w);
`endif
  endtask

  task automatic issue_rand();
    issue_model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                24'($urandom()), 24'($urandom()), 23'($urandom()));
  endtask

  // Idle cycle with junk on the data inputs.
  task automatic idle();
    valid_i         = 1'b0;
    sel_red_i       = 1'($urandom_range(0, 1));
    sel_butterfly_i = 1'($urandom_range(0, 1));
    a_i             = 24'($urandom());
    b_i             = 24'($urandom());
    twiddle_i       = 23'($urandom());
    step();
  endtask

  initial begin
    rst_i           = 1'b1;
    valid_i         = 1'b0;
    sel_red_i       = 1'b0;
    sel_butterfly_i = 1'b0;
    a_i             = '0;
    b_i             = '0;
    twiddle_i       = '0;
    step();
    step();
    rst_i = 1'b0;
    idle();

    // Reference vectors, one at a time.
    issue_kyber(1'b0, 24'd3210, 24'd19, 23'd281, 23'd1891, 23'd1200);
    repeat (3) idle();
    issue_kyber(1'b1, 24'd1891, 24'd1200, 23'd281, 23'd3091, 23'd1089);
    repeat (3) idle();
    issue(1'b0, 1'b0, 24'd8297430, 24'd7194, 23'd400232, 23'd4702990, 23'd3511453);
    repeat (3) idle();
    issue(1'b0, 1'b1, 24'd4702990, 24'd3511453, 23'd400232, 23'd8214443, 23'd3607199);
    repeat (3) idle();

    // The same four back to back, with alternating modes.
    issue_kyber(1'b0, 24'd3210, 24'd19, 23'd281, 23'd1891, 23'd1200);
    issue(1'b0, 1'b0, 24'd8297430, 24'd7194, 23'd400232, 23'd4702990, 23'd3511453);
    issue_kyber(1'b1, 24'd1891, 24'd1200, 23'd281, 23'd3091, 23'd1089);
    issue(1'b0, 1'b1, 24'd4702990, 24'd3511453, 23'd400232, 23'd8214443, 23'd3607199);
    repeat (3) idle();

    // Boundaries: fields at or above q, bit 23 set, and GS with a == b (b' = 0).
    issue_model(1'b0, 1'b0, 24'hFFFFFF, 24'd8380417, 23'd8380416);
    issue_model(1'b0, 1'b1, 24'd8380416, 24'd8380416, 23'd8380416);
    issue_model(1'b1, 1'b0, 24'hFFFFFF, 24'hFFF000 | 24'd3329, 23'h7FFFFF);
    issue_model(1'b1, 1'b1, 24'd3328, 24'd3328, 23'd3328);
    issue_model(1'b0, 1'b1, 24'd5, 24'd9, 23'd0);
    repeat (3) idle();

    // Random traffic with occasional gaps.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) issue_rand();
      else idle();
    end
    repeat (3) idle();

    // Reset with two operations in flight: neither may ever appear.
    issue_rand();
    issue_rand();
    valid_i = 1'b0;
    rst_i   = 1'b1;
    sb.delete();
    last_a = '0;
    last_b = '0;
    step();
    step();
    rst_i = 1'b0;
    repeat (4) idle();

    // First operation after reset, then more random traffic.
    issue_rand();
    repeat (3) idle();
    for (int i = 0; i < 20; i++) issue_rand();
    repeat (4) idle();

    if (sb.size() != 0) check("scoreboard_drained", 23'(sb.size()), 23'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
